svc_rv_idex: RTL

ID→EX pipeline register for the svc_rv core, fed directly by the ID-stage forward unit. It captures the forwarded operands and decoded control into EX and detects load-use and CSR-use hazards that ID forwarding cannot resolve. On such a hazard it stalls ID and inserts EX bubbles. It also applies EX-side stall and flush.

---
 rtl/svc_rv_idex.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/svc_rv_idex.sv
`default_nettype none
// ============================================================================
// Module   : svc_rv_idex
// Purpose  : ID->EX pipeline register for the svc_rv core. Captures forwarded
//            operands and decoded control, detects load-use / CSR-use hazards
//            that ID forwarding cannot cover, inserts EX bubbles and applies
//            EX-side stall and flush.
// Options  : SVC_RV_IDEX_BUBBLE_CLR_EN - bubbles and flushes also zero the
//            payload registers (default: only valid/reg_write clear).
// Revision : 1.0 - initial release
// ============================================================================
module svc_rv_idex #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            valid_id,
    output logic            ready_id,
    input  logic [4:0]      rs1_id,
    input  logic [4:0]      rs2_id,
    input  logic            rs1_used_id,
    input  logic            rs2_used_id,
    input  logic [XLEN-1:0] fwd_rs1_id,
    input  logic [XLEN-1:0] fwd_rs2_id,
    input  logic [4:0]      rd_id,
    input  logic            reg_write_id,
    input  logic [2:0]      res_src_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [XLEN-1:0] pc_id,

    input  logic            stall_ex,
    input  logic            flush_ex,

    output logic            valid_ex,
    output logic            reg_write_ex,
    output logic [4:0]      rs1_ex,
    output logic [4:0]      rs2_ex,
    output logic [4:0]      rd_ex,
    output logic [2:0]      res_src_ex,
    output logic [XLEN-1:0] rs1_data_ex,
    output logic [XLEN-1:0] rs2_data_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [XLEN-1:0] pc_ex,

    output logic            hazard_id
);

    localparam logic [2:0] c_RES_LOAD = 3'd1;
    localparam logic [2:0] c_RES_CSR  = 3'd4;

    logic            r_valid_ex;
    logic            r_reg_write_ex;
    logic [4:0]      r_rs1_ex;
    logic [4:0]      r_rs2_ex;
    logic [4:0]      r_rd_ex;
    logic [2:0]      r_res_src_ex;
    logic [XLEN-1:0] r_rs1_data_ex;
    logic [XLEN-1:0] r_rs2_data_ex;
    logic [XLEN-1:0] r_imm_ex;
    logic [XLEN-1:0] r_pc_ex;

    // Shadow of a CSR writer that has moved on to MEM (not forwarded from MEM)
    logic            r_csr_mem_vld;
    logic [4:0]      r_csr_mem_rd;

    logic w_ex_late_res;
    logic w_ex_csr_wr;
    logic w_haz_ex;
    logic w_haz_mem;
    logic w_hazard;

    // Hazard detection against the EX instruction and the MEM-stage CSR shadow
    always_comb begin
        w_ex_late_res = (r_res_src_ex == c_RES_LOAD) || (r_res_src_ex == c_RES_CSR);
        w_ex_csr_wr   = r_valid_ex && r_reg_write_ex && (r_res_src_ex == c_RES_CSR)
                        && (r_rd_ex != 5'd0);
        w_haz_ex      = r_valid_ex && r_reg_write_ex && (r_rd_ex != 5'd0) && w_ex_late_res
                        && ((rs1_used_id && (rs1_id == r_rd_ex))
                            || (rs2_used_id && (rs2_id == r_rd_ex)));
        w_haz_mem     = valid_id && r_csr_mem_vld
                        && ((rs1_used_id && (rs1_id == r_csr_mem_rd))
                            || (rs2_used_id && (rs2_id == r_csr_mem_rd)));
        w_hazard      = valid_id && (w_haz_ex || w_haz_mem) && !flush_ex;
    end

    assign hazard_id = w_hazard;
    assign ready_id  = flush_ex || (!stall_ex && !w_hazard);

    // CSR shadow follows every EX advance; flushes do not affect it (older instr)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_csr_mem_vld <= 1'b0;
            r_csr_mem_rd  <= 5'd0;
        end else if (!stall_ex) begin
            r_csr_mem_vld <= w_ex_csr_wr;
            r_csr_mem_rd  <= r_rd_ex;
        end
    end

    // EX pipeline register: flush > stall > bubble > capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_ex     <= 1'b0;
            r_reg_write_ex <= 1'b0;
            r_rs1_ex       <= 5'd0;
            r_rs2_ex       <= 5'd0;
            r_rd_ex        <= 5'd0;
            r_res_src_ex   <= 3'd0;
            r_rs1_data_ex  <= '0;
            r_rs2_data_ex  <= '0;
            r_imm_ex       <= '0;
            r_pc_ex        <= '0;
        end else if (flush_ex || (!stall_ex && w_hazard)) begin
            r_valid_ex     <= 1'b0;
            r_reg_write_ex <= 1'b0;
`ifdef SVC_RV_IDEX_BUBBLE_CLR_EN
            r_rs1_ex       <= 5'd0;
            r_rs2_ex       <= 5'd0;
            r_rd_ex        <= 5'd0;
            r_res_src_ex   <= 3'd0;
            r_rs1_data_ex  <= '0;
            r_rs2_data_ex  <= '0;
            r_imm_ex       <= '0;
            r_pc_ex        <= '0;
`else
            // Payload holds; consumers must qualify it with valid_ex
`endif
        end else if (!stall_ex) begin
            r_valid_ex     <= valid_id;
            r_reg_write_ex <= reg_write_id && valid_id;
            r_rs1_ex       <= rs1_id;
            r_rs2_ex       <= rs2_id;
            r_rd_ex        <= rd_id;
            r_res_src_ex   <= res_src_id;
            r_rs1_data_ex  <= fwd_rs1_id;
            r_rs2_data_ex  <= fwd_rs2_id;
            r_imm_ex       <= imm_id;
            r_pc_ex        <= pc_id;
        end
    end

    assign valid_ex     = r_valid_ex;
    assign reg_write_ex = r_reg_write_ex;
    assign rs1_ex       = r_rs1_ex;
    assign rs2_ex       = r_rs2_ex;
    assign rd_ex        = r_rd_ex;
    assign res_src_ex   = r_res_src_ex;
    assign rs1_data_ex  = r_rs1_data_ex;
    assign rs2_data_ex  = r_rs2_data_ex;
    assign imm_ex       = r_imm_ex;
    assign pc_ex        = r_pc_ex;

endmodule
`default_nettype wire
